// File: rtl/bist_sequencer.sv
// Self-test sequencer for the scan-inserted CUT.
// Runs seed -> (shift, capture) x N_PATTERNS -> flush -> compare against GOLDEN_SIG, then
// holds bistdone/bistpass until bistmode drops. All outputs are registered Moore decodes.
// Ports:
//   clk       - single clock, all state on rising edge
//   rst       - asynchronous active-low reset
//   bistmode  - 1 = run/hold BIST, 0 = functional mode / abort
//   misr_sig  - current MISR contents, sampled only in COMPARE
//   test_sel  - CUT PIs from LFSR, POs to MISR
//   gen_init  - one-cycle pulse: load LFSR seed, clear MISR
//   lfsr_en   - advance LFSR
//   scan_en   - 1 = scan shift, 0 = functional capture
//   misr_en   - MISR compacts this cycle
//   bistdone  - run complete, bistpass valid
//   bistpass  - signature matched GOLDEN_SIG
module bist_sequencer #(
   parameter int unsigned          N_PATTERNS = 2000,
   parameter int unsigned          CHAIN_LEN  = 179,
   parameter int unsigned          SIG_WIDTH  = 16,
   parameter logic [SIG_WIDTH-1:0] GOLDEN_SIG = 16'hA5C3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 bistmode,
   input  logic [SIG_WIDTH-1:0] misr_sig,
   output logic                 test_sel,
   output logic                 gen_init,
   output logic                 lfsr_en,
   output logic                 scan_en,
   output logic                 misr_en,
   output logic                 bistdone,
   output logic                 bistpass
);

   localparam int unsigned SHIFT_W = $clog2(CHAIN_LEN + 1);
   localparam int unsigned PAT_W   = $clog2(N_PATTERNS + 1);

   localparam logic [SHIFT_W-1:0] SHIFT_LAST = SHIFT_W'(CHAIN_LEN - 1);
   localparam logic [PAT_W-1:0]   PAT_LAST   = PAT_W'(N_PATTERNS - 1);

   localparam logic [2:0] StIdle    = 3'd0;
   localparam logic [2:0] StInit    = 3'd1;
   localparam logic [2:0] StShift   = 3'd2;
   localparam logic [2:0] StCapture = 3'd3;
   localparam logic [2:0] StFlush   = 3'd4;
   localparam logic [2:0] StCompare = 3'd5;
   localparam logic [2:0] StDone    = 3'd6;

   logic [2:0]         state_q, state_d;
   logic [SHIFT_W-1:0] shift_cnt_q, shift_cnt_d;
   logic [PAT_W-1:0]   pat_cnt_q, pat_cnt_d;
   logic               first_q, first_d;
   logic               pass_q, pass_d;

   logic test_sel_d, gen_init_d, lfsr_en_d, scan_en_d, misr_en_d, bistdone_d, bistpass_d;

   always_comb begin
      state_d     = state_q;
      shift_cnt_d = shift_cnt_q;
      pat_cnt_d   = pat_cnt_q;
      first_d     = first_q;
      pass_d      = pass_q;

      if (!bistmode && (state_q != StIdle)) begin
         // Abort from any active state, or normal exit from DONE: drop everything.
         state_d     = StIdle;
         shift_cnt_d = '0;
         pat_cnt_d   = '0;
         first_d     = 1'b0;
         pass_d      = 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               if (bistmode) state_d = StInit;
            end
            StInit: begin
               shift_cnt_d = '0;
               pat_cnt_d   = '0;
               first_d     = 1'b1;
               pass_d      = 1'b0;
               state_d     = StShift;
            end
            StShift: begin
               if (shift_cnt_q == SHIFT_LAST) state_d = StCapture;
               else shift_cnt_d = shift_cnt_q + 1'b1;
            end
            StCapture: begin
               first_d     = 1'b0;
               shift_cnt_d = '0;
               if (pat_cnt_q == PAT_LAST) begin
                  state_d = StFlush;
               end else begin
                  pat_cnt_d = pat_cnt_q + 1'b1;
                  state_d   = StShift;
               end
            end
            StFlush: begin
               if (shift_cnt_q == SHIFT_LAST) begin
                  shift_cnt_d = '0;
                  state_d     = StCompare;
               end else begin
                  shift_cnt_d = shift_cnt_q + 1'b1;
               end
            end
            StCompare: begin
               pass_d  = (misr_sig == GOLDEN_SIG);
               state_d = StDone;
            end
            StDone: begin
               // Held while bistmode stays high; exit handled by the abort branch.
            end
            default: begin
               state_d     = StIdle;
               shift_cnt_d = '0;
               pat_cnt_d   = '0;
               first_d     = 1'b0;
               pass_d      = 1'b0;
            end
         endcase
      end
   end

   // Outputs are decoded from the next state so the registered copies line up with state_q.
   always_comb begin
      test_sel_d = (state_d != StIdle);
      gen_init_d = (state_d == StInit);
      lfsr_en_d  = (state_d == StShift);
      scan_en_d  = (state_d == StShift) || (state_d == StFlush);
      // The first shift only unloads the chain's reset contents, so it is not compacted.
      misr_en_d  = ((state_d == StShift) && !first_d) || (state_d == StCapture) ||
                   (state_d == StFlush);
      bistdone_d = (state_d == StDone);
      bistpass_d = (state_d == StDone) && pass_d;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= StIdle;
         shift_cnt_q <= '0;
         pat_cnt_q   <= '0;
         first_q     <= 1'b0;
         pass_q      <= 1'b0;
         test_sel    <= 1'b0;
         gen_init    <= 1'b0;
         lfsr_en     <= 1'b0;
         scan_en     <= 1'b0;
         misr_en     <= 1'b0;
         bistdone    <= 1'b0;
         bistpass    <= 1'b0;
      end else begin
         state_q     <= state_d;
         shift_cnt_q <= shift_cnt_d;
         pat_cnt_q   <= pat_cnt_d;
         first_q     <= first_d;
         pass_q      <= pass_d;
         test_sel    <= test_sel_d;
         gen_init    <= gen_init_d;
         lfsr_en     <= lfsr_en_d;
         scan_en     <= scan_en_d;
         misr_en     <= misr_en_d;
         bistdone    <= bistdone_d;
         bistpass    <= bistpass_d;
      end
   end

endmodule

// File: tb/tb_bist_sequencer.sv
// Bench for bist_sequencer with N_PATTERNS=4, CHAIN_LEN=3, GOLDEN_SIG=16'h1234.
// A cycle-level reference model derives the expected output bundle from the run's cycle index
// with plain arithmetic and queues it; a monitor pops and compares on the falling edge.
module tb_bist_sequencer;

   localparam int          NP     = 4;
   localparam int          CL     = 3;
   localparam int          LP     = CL + 1;          // cycles per pattern (shift + capture)
   localparam int          CMP_T  = NP * LP + CL + 1; // COMPARE cycle index, INIT = 0
   localparam logic [15:0] GOLDEN = 16'h1234;

   logic        clk;
   logic        rst;
   logic        bistmode;
   logic [15:0] misr_sig;
   logic        test_sel, gen_init, lfsr_en, scan_en, misr_en, bistdone, bistpass;
   logic [6:0]  outs;

   assign outs = {test_sel, gen_init, lfsr_en, scan_en, misr_en, bistdone, bistpass};

   bist_sequencer #(
      .N_PATTERNS (NP),
      .CHAIN_LEN  (CL),
      .SIG_WIDTH  (16),
      .GOLDEN_SIG (GOLDEN)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .bistmode (bistmode),
      .misr_sig (misr_sig),
      .test_sel (test_sel),
      .gen_init (gen_init),
      .lfsr_en  (lfsr_en),
      .scan_en  (scan_en),
      .misr_en  (misr_en),
      .bistdone (bistdone),
      .bistpass (bistpass)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;

   logic [6:0]  exp_q[$];
   int          m_mode = 0;  // 0 idle, 1 running, 2 done
   int          m_t    = 0;
   bit          m_pass = 1'b0;
   logic [15:0] misr_target;

   // Expected {test_sel, gen_init, lfsr_en, scan_en, misr_en, bistdone, bistpass}.
   function automatic logic [6:0] expect_vec(input int mode, input int t, input bit pass);
      int p, s;
      if (mode == 0) return 7'b0;
      if (mode == 2) return {1'b1, 4'b0, 1'b1, pass};
      if (t == 0) return 7'b1100000;
      if (t <= NP * LP) begin
         p = (t - 1) / LP;
         s = (t - 1) % LP;
         if (s < CL) return {1'b1, 1'b0, 1'b1, 1'b1, (p != 0), 2'b0};
         return 7'b1000100;
      end
      if (t <= NP * LP + CL) return 7'b1001100;
      return 7'b1000000;
   endfunction

   task automatic chk_vec(input string name, input logic [6:0] act, input logic [6:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: outputs %b, required %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, required %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: advances on each rising edge from the inputs sampled at that edge.
   initial forever begin
      @(posedge clk);
      if (!rst) begin
         m_mode = 0;
         m_t    = 0;
         m_pass = 1'b0;
      end else begin
         case (m_mode)
            0: if (bistmode) begin
                  m_mode = 1;
                  m_t    = 0;
               end
            1: if (!bistmode) m_mode = 0;
               else if (m_t == CMP_T) begin
                  m_pass = (misr_sig == GOLDEN);
                  m_mode = 2;
               end else m_t++;
            default: if (!bistmode) begin
                  m_mode = 0;
                  m_pass = 1'b0;
               end
         endcase
      end
      exp_q.push_back(expect_vec(m_mode, m_t, m_pass));
   end

   // Monitor: compares every cycle the DUT is out of reset; reset cycles are checked directly.
   initial forever begin
      logic [6:0] e;
      @(negedge clk);
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (rst) chk_vec("cycle_outputs", outs, e);
      end
   end

   // misr_sig is noise except in the cycle the model says the DUT is in COMPARE.
   initial forever begin
      @(posedge clk);
      #2;
      if (m_mode == 1 && m_t == CMP_T) misr_sig = misr_target;
      else misr_sig = 16'($urandom);
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   // Call right after raising bistmode; the next edge enters INIT (cycle 0).
   task automatic run_timed(input string name);
      int cyc;
      cyc = -1;
      for (int i = 0; i < 200; i++) begin
         @(posedge clk);
         #2;
         if (bistdone === 1'b1) begin
            cyc = i;
            break;
         end
      end
      chk_int(name, cyc, CMP_T + 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int abort_at;
      rst         = 1'b0;
      bistmode    = 1'b0;
      misr_sig    = 16'h0;
      misr_target = GOLDEN;
      #1;
      chk_vec("reset_state", outs, 7'b0);
      tick(3);
      @(negedge clk);
      #2;
      rst = 1'b1;
      tick(3);

      // Nominal pass, held for a while.
      bistmode = 1'b1;
      run_timed("pass_latency");
      chk_int("pass_flag", int'(bistpass), 1);
      tick(12);
      bistmode = 1'b0;
      tick(2);

      // Signature mismatch.
      misr_target = 16'h1235;
      bistmode    = 1'b1;
      run_timed("fail_latency");
      chk_int("fail_flag", int'(bistpass), 0);
      tick(10);
      bistmode = 1'b0;
      tick(2);
      misr_target = GOLDEN;

      // Abort mid-SHIFT at cycle 9, then a clean rerun.
      bistmode = 1'b1;
      tick(10);
      bistmode = 1'b0;
      tick(1);
      chk_vec("abort_idle", outs, 7'b0);
      tick(5);
      bistmode = 1'b1;
      run_timed("abort_rerun_latency");
      tick(3);
      bistmode = 1'b0;
      tick(2);

      // Asynchronous reset in the CAPTURE at cycle 8, released with bistmode still high.
      bistmode = 1'b1;
      tick(9);
      #1;
      rst = 1'b0;
      #1;
      chk_vec("async_reset", outs, 7'b0);
      @(posedge clk);
      @(negedge clk);
      #2;
      rst = 1'b1;
      run_timed("reset_rerun_latency");

      // Held bistmode must not re-run; a one-cycle drop restarts.
      tick(50);
      bistmode = 1'b0;
      tick(1);
      bistmode = 1'b1;
      run_timed("restart_latency");
      tick(3);
      bistmode = 1'b0;
      tick(2);

      // Randomised runs: random signature, optional abort at a random cycle.
      for (int r = 0; r < 8; r++) begin
         misr_target = ($urandom_range(0, 1) == 1) ? GOLDEN : 16'($urandom);
         abort_at    = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, CMP_T)) : -1;
         bistmode    = 1'b1;
         if (abort_at >= 0) begin
            tick(abort_at + 1);
            bistmode = 1'b0;
            tick(int'($urandom_range(1, 4)));
         end else begin
            run_timed("random_latency");
            chk_int("random_pass", int'(bistpass), int'(misr_target == GOLDEN));
            tick(int'($urandom_range(1, 5)));
            bistmode = 1'b0;
            tick(int'($urandom_range(1, 3)));
         end
      end

      tick(2);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
